ro_puf_engine: RTL and testbench

Parametrised ring-oscillator PUF measurement engine. It sits between an external free-running oscillator bank and the chip I/O. For each of RESP_BITS response bits it selects an oscillator pair from a challenge, synchronises both oscillator outputs into the `clk` domain, counts their rising edges over a programmable window, and compares the counts. The block adds a start/busy/valid handshake, multi-bit responses, saturation and tie reporting, and oscillator gating, none of which the earlier single-comparison design has.

---
 rtl/ro_puf_engine.sv | 168 ++++++++++++++++
 tb/tb_ro_puf_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ro_puf_engine.sv
// rtl/ro_puf_engine.sv - ring-oscillator PUF engine: per-bit pair select, edge count over a window, compare
module ro_puf_engine #(
    parameter int N_RO       = 16,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int RESP_BITS  = 8,
    parameter int SETTLE_CYC = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_RO-1:0]                ro_in,
    output logic                           ro_en,
    input  logic                           start,
    input  logic [SEL_W-1:0]               chal_a,
    input  logic [SEL_W-1:0]               chal_b,
    input  logic [WIN_W-1:0]               win_len,
    output logic                           busy,
    output logic                           resp_valid,
    output logic [RESP_BITS-1:0]           resp,
    output logic [$clog2(RESP_BITS+1)-1:0] tie_cnt,
    output logic                           sat,
    output logic                           err
);
    localparam int TW = $clog2(RESP_BITS + 1);
    localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SEL_W:0]   NRO_L    = (SEL_W + 1)'(N_RO);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_RO - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'(RESP_BITS - 1);
    localparam logic [SW-1:0]    SET_LOAD = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_COUNT, S_COMPARE, S_DONE
    } state_t;

    state_t                 state_q;
    logic [N_RO-1:0]        s1_q, s2_q, s3_q;
    logic [N_RO-1:0]        edge_w;
    logic [SEL_W-1:0]       a_q, b_q;
    logic [WIN_W-1:0]       win_q, win_cnt_q;
    logic [SW-1:0]          set_cnt_q;
    logic [KW-1:0]          k_q;
    logic [CNT_W-1:0]       cnt_a_q, cnt_b_q;
    logic [RESP_BITS-1:0]   resp_q;
    logic [TW-1:0]          tie_q;
    logic                   sat_q, err_q, busy_q, ro_en_q, valid_q;
    logic                   start_ok;
    logic                   edge_a, edge_b;

    // Free-running synchroniser; history flop turns each pulse into a single-cycle edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= ro_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_w = s2_q & ~s3_q;
    assign edge_a = edge_w[a_q];
    assign edge_b = edge_w[b_q];

    assign start_ok = ({1'b0, chal_a} < NRO_L) && ({1'b0, chal_b} < NRO_L)
                   && (chal_a != chal_b) && (win_len != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            win_q     <= '0;
            win_cnt_q <= '0;
            set_cnt_q <= '0;
            k_q       <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            resp_q    <= '0;
            tie_q     <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            ro_en_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            a_q       <= chal_a;
                            b_q       <= chal_b;
                            win_q     <= win_len;
                            cnt_a_q   <= '0;
                            cnt_b_q   <= '0;
                            tie_q     <= '0;
                            sat_q     <= 1'b0;
                            valid_q   <= 1'b0;
                            k_q       <= '0;
                            set_cnt_q <= SET_LOAD;
                            busy_q    <= 1'b1;
                            ro_en_q   <= 1'b1;
                            state_q   <= S_SETTLE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (set_cnt_q == '0) begin
                        win_cnt_q <= win_q - WIN_W'(1);
                        state_q   <= S_COUNT;
                    end else begin
                        set_cnt_q <= set_cnt_q - SW'(1);
                    end
                end
                S_COUNT: begin
                    if (edge_a) begin
                        if (cnt_a_q == CNT_MAX) sat_q <= 1'b1;
                        else                    cnt_a_q <= cnt_a_q + CNT_W'(1);
                    end
                    if (edge_b) begin
                        if (cnt_b_q == CNT_MAX) sat_q <= 1'b1;
                        else                    cnt_b_q <= cnt_b_q + CNT_W'(1);
                    end
                    if (win_cnt_q == '0) state_q <= S_COMPARE;
                    else                 win_cnt_q <= win_cnt_q - WIN_W'(1);
                end
                S_COMPARE: begin
                    resp_q[k_q] <= (cnt_a_q > cnt_b_q);
                    if (cnt_a_q == cnt_b_q) tie_q <= tie_q + TW'(1);
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                    if (k_q == K_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        k_q       <= k_q + KW'(1);
                        a_q       <= (a_q == IDX_LAST) ? '0 : a_q + SEL_W'(1);
                        b_q       <= (b_q == IDX_LAST) ? '0 : b_q + SEL_W'(1);
                        set_cnt_q <= SET_LOAD;
                        state_q   <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    // busy falls exactly as resp_valid rises; a start seen here is dropped.
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    ro_en_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ro_en      = ro_en_q;
    assign busy       = busy_q;
    assign resp_valid = valid_q;
    assign resp       = resp_q;
    assign tie_cnt    = tie_q;
    assign sat        = sat_q;
    assign err        = err_q;
endmodule

// File: tb/tb_ro_puf_engine.sv
// tb/tb_ro_puf_engine.sv - directed bench for ro_puf_engine with synthetic oscillator bank
module tb_ro_puf_engine;
    logic        clk;
    logic        rst_n;
    logic [15:0] ro_in;
    logic        ro_en;
    logic        start;
    logic [3:0]  chal_a;
    logic [3:0]  chal_b;
    logic [15:0] win_len;
    logic        busy;
    logic        resp_valid;
    logic [7:0]  resp;
    logic [3:0]  tie_cnt;
    logic        sat;
    logic        err;

    int checks = 0;
    int errors = 0;
    int per [16];
    int tick;

    ro_puf_engine #(
        .N_RO(16), .SEL_W(4), .CNT_W(5), .WIN_W(16), .RESP_BITS(8), .SETTLE_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en), .start(start),
        .chal_a(chal_a), .chal_b(chal_b), .win_len(win_len), .busy(busy),
        .resp_valid(resp_valid), .resp(resp), .tie_cnt(tie_cnt), .sat(sat), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator bank: period per[i] clk cycles, 50% duty, all in phase; 0 means stopped low.
    initial begin
        ro_in = '0;
        tick  = 0;
        #2;
        forever begin
            #5;
            tick++;
            for (int i = 0; i < 16; i++)
                ro_in[i] = (per[i] != 0) && ((tick % (2 * per[i])) < per[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_per(input int lo_p, input int hi_p);
        for (int i = 0; i < 16; i++) per[i] = (i < 8) ? lo_p : hi_p;
    endtask

    task automatic pulse_start(input logic [3:0] a, input logic [3:0] b, input logic [15:0] w);
        @(negedge clk);
        chal_a  = a;
        chal_b  = b;
        win_len = w;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        chal_a  = 4'd0;
        chal_b  = 4'd0;
        win_len = 16'd0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (resp_valid) break;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] w, input logic [7:0] er, input logic [3:0] et,
                       input logic es, input int elat);
        int n;
        pulse_start(a, b, w);
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        wait_valid(n);
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        chk({tag, "_resp"}, {24'd0, resp}, {24'd0, er});
        chk({tag, "_tie"}, {28'd0, tie_cnt}, {28'd0, et});
        chk({tag, "_sat"}, {31'd0, sat}, {31'd0, es});
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        start   = 1'b0;
        chal_a  = 4'd0;
        chal_b  = 4'd0;
        win_len = 16'd0;
        for (int i = 0; i < 16; i++) per[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {ro_en, busy, resp_valid, resp, tie_cnt, sat, err},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bits 0 and 2 see an active A against a slower/idle B; the rest are idle-idle ties.
        per[3] = 4;
        per[5] = 6;
        run("basic", 4'd3, 4'd5, 16'd100, 8'h05, 4'd6, 1'b0, 8 * (8 + 100 + 1) + 1);

        set_per(4, 8);
        run("walk", 4'd0, 4'd8, 16'd64, 8'hFF, 4'd0, 1'b0, 8 * (8 + 64 + 1) + 1);
        run("walk_swap", 4'd8, 4'd0, 16'd64, 8'h00, 4'd0, 1'b0, 8 * (8 + 64 + 1) + 1);

        set_per(4, 4);
        run("tie_wrap", 4'd15, 4'd0, 16'd40, 8'h00, 4'd8, 1'b0, 8 * (8 + 40 + 1) + 1);

        set_per(4, 8);
        run("saturate", 4'd0, 4'd8, 16'd200, 8'hFF, 4'd0, 1'b1, 8 * (8 + 200 + 1) + 1);

        pulse_start(4'd2, 4'd2, 16'd10);
        chk("rej_eq_err", {31'd0, err}, 32'd1);
        chk("rej_eq_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("rej_eq_err_clear", {31'd0, err}, 32'd0);
        pulse_start(4'd1, 4'd9, 16'd0);
        chk("rej_win0_err", {31'd0, err}, 32'd1);
        chk("rej_keep", {22'd0, busy, resp_valid, resp}, {22'd0, 1'b0, 1'b1, 8'hFF});
        chk("rej_keep_sat", {31'd0, sat}, 32'd1);

        // Start pulse mid-run must be ignored without err.
        pulse_start(4'd8, 4'd0, 16'd64);
        repeat (20) @(posedge clk);
        pulse_start(4'd5, 4'd5, 16'd3);
        chk("busy_start_no_err", {30'd0, err, busy}, 32'd1);
        wait_valid(n);
        chk("busy_start_latency", n + 21, 8 * (8 + 64 + 1) + 1);
        chk("busy_start_resp", {24'd0, resp}, 32'h00);

        // Bit 3 COUNT spans cycles 227..290 after the start edge.
        pulse_start(4'd0, 4'd8, 16'd64);
        repeat (250) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {ro_en, busy, resp_valid, resp, tie_cnt, sat, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run("after_rst", 4'd0, 4'd8, 16'd64, 8'hFF, 4'd0, 1'b0, 8 * (8 + 64 + 1) + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
